iseq_loader: RTL and testbench

- Write side of the instruction-sequence path.
- Accepts 32-bit instruction words from the host stream and distributes them alternately into the instr0/instr1 FIFOs (even slot → instr0, odd slot → instr1).
- On an end-of-sequence word, pads odd-length sequences, pulses process_iseq to start the dispatcher, and holds off the host until the dispatcher drains both FIFOs.

---
 rtl/iseq_pkg.sv | 23 ++
 rtl/iseq_loader.sv | 162 ++++++++++++++++
 tb/tb_iseq_loader.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iseq_pkg.sv
// Shared opcode constants and loader state encoding for the instruction-sequence path.
// Used by both the loader (write side) and the dispatcher (read side).
package iseq_pkg;

    localparam int ISEQ_OP_MSB = 31;
    localparam int ISEQ_OP_LSB = 28;

    localparam logic [3:0] ISEQ_OP_END = 4'hF;
    localparam logic [3:0] ISEQ_OP_NOP = 4'h0;

    typedef enum logic [2:0] {
        LD_LOAD      = 3'd0,
        LD_PAD       = 3'd1,
        LD_KICK      = 3'd2,
        LD_WAIT_ACC  = 3'd3,
        LD_WAIT_DONE = 3'd4
    } iseq_ld_state_e;

    function automatic logic [3:0] iseq_opcode(input logic [31:0] word);
        return word[ISEQ_OP_MSB:ISEQ_OP_LSB];
    endfunction

endpackage

// File: rtl/iseq_loader.sv
// Write side of the instruction-sequence path: splits host words across instr0/instr1 FIFOs.
// Optional macro ISEQ_LOADER_STATS_EN adds the iseq_kick_cnt output.
module iseq_loader
    import iseq_pkg::*;
#(
    parameter int          CNT_WIDTH = 11,
    parameter logic [31:0] NOP_WORD  = {ISEQ_OP_NOP, 28'h000_0000}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 host_valid,
    input  logic [31:0]          host_data,
    output logic                 host_ready,
    output logic                 instr0_fifo_wr,
    output logic [31:0]          instr0_fifo_data,
    input  logic                 instr0_fifo_full,
    output logic                 instr1_fifo_wr,
    output logic [31:0]          instr1_fifo_data,
    input  logic                 instr1_fifo_full,
    output logic                 process_iseq,
    input  logic                 dispatcher_busy,
    output logic                 loader_busy,
`ifdef ISEQ_LOADER_STATS_EN
    output logic [15:0]          iseq_kick_cnt,
`endif
    output logic [CNT_WIDTH-1:0] iseq_len
);

    iseq_ld_state_e         state_r;
    iseq_ld_state_e         state_next_s;
    logic                   sel_r;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic [CNT_WIDTH-1:0]   iseq_len_r;

    logic                   target_full_s;
    logic                   is_end_s;
    logic                   host_ready_s;
    logic                   load_word_s;
    logic                   end_kick_s;
    logic                   pad_wr_s;
    logic                   wr0_s;
    logic                   wr1_s;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign target_full_s = sel_r ? instr1_fifo_full : instr0_fifo_full;
    assign is_end_s      = (iseq_opcode(host_data) == ISEQ_OP_END);

    // Next-state, handshake and write-strobe decode
    always_comb begin
        state_next_s = state_r;
        host_ready_s = 1'b0;
        load_word_s  = 1'b0;
        end_kick_s   = 1'b0;
        pad_wr_s     = 1'b0;
        wr0_s        = 1'b0;
        wr1_s        = 1'b0;
        case (state_r)
            LD_LOAD: begin
                host_ready_s = ~target_full_s;
                if (host_valid && host_ready_s) begin
                    if (!is_end_s) begin
                        load_word_s = 1'b1;
                        wr0_s       = ~sel_r;
                        wr1_s       = sel_r;
                    end else if (cnt_r == {CNT_WIDTH{1'b0}}) begin
                        // Empty sequence: END is swallowed without starting the dispatcher
                        state_next_s = LD_LOAD;
                    end else if (sel_r) begin
                        state_next_s = LD_PAD;
                    end else begin
                        end_kick_s   = 1'b1;
                        state_next_s = LD_KICK;
                    end
                end else begin
                    state_next_s = LD_LOAD;
                end
            end
            LD_PAD: begin
                if (!instr1_fifo_full) begin
                    pad_wr_s     = 1'b1;
                    wr1_s        = 1'b1;
                    state_next_s = LD_KICK;
                end else begin
                    state_next_s = LD_PAD;
                end
            end
            LD_KICK: begin
                state_next_s = LD_WAIT_ACC;
            end
            LD_WAIT_ACC: begin
                if (dispatcher_busy) begin
                    state_next_s = LD_WAIT_DONE;
                end else begin
                    state_next_s = LD_WAIT_ACC;
                end
            end
            LD_WAIT_DONE: begin
                if (!dispatcher_busy) begin
                    state_next_s = LD_LOAD;
                end else begin
                    state_next_s = LD_WAIT_DONE;
                end
            end
            default: begin
                state_next_s = LD_LOAD;
            end
        endcase
    end

    // State, slot select, word counter and reported length
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= LD_LOAD;
            sel_r      <= 1'b0;
            cnt_r      <= {CNT_WIDTH{1'b0}};
            iseq_len_r <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (load_word_s) begin
                sel_r <= ~sel_r;
                cnt_r <= sat_inc(cnt_r);
            end else if (state_r == LD_KICK) begin
                sel_r <= 1'b0;
                cnt_r <= {CNT_WIDTH{1'b0}};
            end
            if (end_kick_s) begin
                iseq_len_r <= cnt_r;
            end else if (pad_wr_s) begin
                iseq_len_r <= sat_inc(cnt_r);
            end
        end
    end

`ifdef ISEQ_LOADER_STATS_EN
    logic [15:0] kick_cnt_r;

    // Free-running count of dispatcher kicks, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            kick_cnt_r <= 16'h0000;
        end else if (state_r == LD_KICK) begin
            kick_cnt_r <= kick_cnt_r + 16'h0001;
        end
    end

    assign iseq_kick_cnt = kick_cnt_r;
`endif

    // Host data goes straight to the targeted FIFO; instr1 carries the pad word in PAD
    assign host_ready       = host_ready_s;
    assign instr0_fifo_wr   = wr0_s;
    assign instr1_fifo_wr   = wr1_s;
    assign instr0_fifo_data = host_data;
    assign instr1_fifo_data = (state_r == LD_PAD) ? NOP_WORD : host_data;
    assign process_iseq     = (state_r == LD_KICK);
    assign loader_busy      = (state_r != LD_LOAD);
    assign iseq_len         = iseq_len_r;

endmodule

// File: tb/tb_iseq_loader.sv
// Directed self-checking bench for iseq_loader with FIFO write capture and a scripted dispatcher.
module tb_iseq_loader;
    import iseq_pkg::*;

    localparam int          CW    = 11;
    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] END_W = 32'hF000_0000;
    localparam logic [31:0] WA    = 32'h1111_1111;
    localparam logic [31:0] WB    = 32'h2222_2222;
    localparam logic [31:0] WC    = 32'h3333_3333;
    localparam logic [31:0] WD    = 32'h4444_4444;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_valid;
    logic [31:0]   host_data;
    logic          host_ready;
    logic          instr0_fifo_wr;
    logic [31:0]   instr0_fifo_data;
    logic          instr0_fifo_full;
    logic          instr1_fifo_wr;
    logic [31:0]   instr1_fifo_data;
    logic          instr1_fifo_full;
    logic          process_iseq;
    logic          dispatcher_busy;
    logic          loader_busy;
    logic [CW-1:0] iseq_len;
`ifdef ISEQ_LOADER_STATS_EN
    logic [15:0]   iseq_kick_cnt;
`endif

    iseq_loader #(.CNT_WIDTH(CW), .NOP_WORD(NOP)) dut (
        .clk              (clk),
        .rst              (rst),
        .host_valid       (host_valid),
        .host_data        (host_data),
        .host_ready       (host_ready),
        .instr0_fifo_wr   (instr0_fifo_wr),
        .instr0_fifo_data (instr0_fifo_data),
        .instr0_fifo_full (instr0_fifo_full),
        .instr1_fifo_wr   (instr1_fifo_wr),
        .instr1_fifo_data (instr1_fifo_data),
        .instr1_fifo_full (instr1_fifo_full),
        .process_iseq     (process_iseq),
        .dispatcher_busy  (dispatcher_busy),
        .loader_busy      (loader_busy),
`ifdef ISEQ_LOADER_STATS_EN
        .iseq_kick_cnt    (iseq_kick_cnt),
`endif
        .iseq_len         (iseq_len)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          cyc = 0;
    int          pulses = 0;
    int          viol = 0;
    int          last_w1 = -1;
    int          last_pulse = -1;
    int          kicks_exp = 0;

    // Capture FIFO writes and pulses; flag writes into full FIFOs or dual writes
    always @(posedge clk) begin
        cyc++;
        if (instr0_fifo_wr) q0.push_back(instr0_fifo_data);
        if (instr1_fifo_wr) begin
            q1.push_back(instr1_fifo_data);
            last_w1 = cyc;
        end
        if (process_iseq) begin
            pulses++;
            last_pulse = cyc;
        end
        if ((instr0_fifo_wr && instr0_fifo_full) || (instr1_fifo_wr && instr1_fifo_full) ||
            (instr0_fifo_wr && instr1_fifo_wr)) viol++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        host_valid = 1'b1;
        host_data  = w;
        #1;
        while (!host_ready && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 50) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        host_valid = 1'b0;
        host_data  = 32'h0;
    endtask

    task automatic wait_pulse(output bit ok);
        ok = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (process_iseq) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
    endtask

    // Called in the KICK cycle; holds dispatcher_busy for 'hold' cycles then releases it
    task automatic dispatch(input int hold);
        int bad;
        bad = 0;
        @(posedge clk); #1;
        dispatcher_busy = 1'b1;
        repeat (hold) begin
            @(posedge clk); #2;
            if (host_ready || !loader_busy) bad++;
        end
        dispatcher_busy = 1'b0;
        #1;
        if (host_ready) bad++;
        @(posedge clk); #2;
        check("busy_hold", bad, 32'd0);
        check("ready_after_busy", host_ready, 32'd1);
        check("idle_after_busy", loader_busy, 32'd0);
    endtask

    initial begin
        int b0, b1, p0, bad;
        bit ok;
        rst = 1'b1; host_valid = 1'b0; host_data = 32'h0;
        instr0_fifo_full = 1'b0; instr1_fifo_full = 1'b0; dispatcher_busy = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", host_ready, 32'd1);
        check("rst_busy", loader_busy, 32'd0);
        check("rst_pulse", process_iseq, 32'd0);
        check("rst_len", iseq_len, 32'd0);
        check("rst_wr", {instr0_fifo_wr, instr1_fifo_wr}, 32'd0);
`ifdef ISEQ_LOADER_STATS_EN
        check("rst_kicks", iseq_kick_cnt, 32'd0);
`endif
        rst = 1'b0;

        // Even-length sequence
        b0 = q0.size(); b1 = q1.size(); p0 = pulses;
        send(WA); send(WB); send(WC); send(WD); send(END_W);
        wait_pulse(ok);
        check("t1_pulse", ok, 32'd1);
        check("t1_len", iseq_len, 32'd4);
        kicks_exp++;
        dispatch(20);
        check("t1_n0", q0.size() - b0, 32'd2);
        check("t1_n1", q1.size() - b1, 32'd2);
        check("t1_q0a", q0[b0], WA);
        check("t1_q0b", q0[b0+1], WC);
        check("t1_q1a", q1[b1], WB);
        check("t1_q1b", q1[b1+1], WD);
        check("t1_npulse", pulses - p0, 32'd1);

        // Odd-length sequence padded with NOP
        b0 = q0.size(); b1 = q1.size(); p0 = pulses;
        send(WA); send(WB); send(WC); send(END_W);
        wait_pulse(ok);
        check("t2_pulse", ok, 32'd1);
        check("t2_len", iseq_len, 32'd4);
        kicks_exp++;
        dispatch(2);
        check("t2_n0", q0.size() - b0, 32'd2);
        check("t2_n1", q1.size() - b1, 32'd2);
        check("t2_q0b", q0[b0+1], WC);
        check("t2_q1a", q1[b1], WB);
        check("t2_pad", q1[b1+1], NOP);
        check("t2_npulse", pulses - p0, 32'd1);
        check("t2_pad_then_pulse", last_pulse - last_w1, 32'd1);

        // END on an empty sequence is ignored
        b0 = q0.size(); b1 = q1.size(); p0 = pulses;
        send(32'hF123_4567);
        repeat (3) @(posedge clk);
        #2;
        check("t3_ready", host_ready, 32'd1);
        check("t3_busy", loader_busy, 32'd0);
        check("t3_writes", (q0.size() - b0) + (q1.size() - b1), 32'd0);
        check("t3_npulse", pulses - p0, 32'd0);

        // Backpressure on the selected FIFO only
        b0 = q0.size(); b1 = q1.size();
        send(WA);
        instr1_fifo_full = 1'b1;
        host_valid = 1'b1; host_data = WB;
        bad = 0;
        repeat (5) begin
            #1;
            if (host_ready) bad++;
            @(posedge clk); #1;
        end
        check("t4_stall", bad, 32'd0);
        check("t4_nowr", q1.size() - b1, 32'd0);
        instr1_fifo_full = 1'b0;
        #1;
        check("t4_ready_drop", host_ready, 32'd1);
        @(posedge clk); #1;
        host_valid = 1'b0;
        check("t4_b_written", q1.size() - b1, 32'd1);
        check("t4_b_val", q1[b1], WB);
        send(WC);
        instr0_fifo_full = 1'b1;
        #1;
        check("t4_other_full", host_ready, 32'd1);
        send(WD);
        instr0_fifo_full = 1'b0;
        send(END_W);
        wait_pulse(ok);
        check("t4_len", iseq_len, 32'd4);
        kicks_exp++;
        dispatch(2);
        check("t4_q0b", q0[b0+1], WC);
        check("t4_q1b", q1[b1+1], WD);
`ifdef ISEQ_LOADER_STATS_EN
        check("t4_kicks", iseq_kick_cnt, kicks_exp);
`endif

        // Reset while stalled in PAD
        b1 = q1.size();
        send(WA);
        host_valid = 1'b1; host_data = END_W;
        @(posedge clk); #1;
        host_valid = 1'b0;
        instr1_fifo_full = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("t5_in_pad", {loader_busy, host_ready}, 32'd2);
        rst = 1'b1;
        @(posedge clk); #2;
        kicks_exp = 0;
        check("t5_busy", loader_busy, 32'd0);
        check("t5_pulse", process_iseq, 32'd0);
        check("t5_len", iseq_len, 32'd0);
        check("t5_ready", host_ready, 32'd1);
        check("t5_nopad", q1.size() - b1, 32'd0);
`ifdef ISEQ_LOADER_STATS_EN
        check("t5_kicks", iseq_kick_cnt, 32'd0);
`endif
        rst = 1'b0;
        instr1_fifo_full = 1'b0;

        // Reset while in WAIT_DONE
        send(WA); send(WB); send(END_W);
        wait_pulse(ok);
        check("t6_pulse", ok, 32'd1);
        @(posedge clk); #1;
        dispatcher_busy = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("t6_in_wait", {loader_busy, host_ready}, 32'd2);
        rst = 1'b1;
        @(posedge clk); #2;
        check("t6_busy", loader_busy, 32'd0);
        check("t6_pulse0", process_iseq, 32'd0);
        check("t6_len", iseq_len, 32'd0);
`ifdef ISEQ_LOADER_STATS_EN
        check("t6_kicks", iseq_kick_cnt, 32'd0);
`endif
        rst = 1'b0;
        dispatcher_busy = 1'b0;

        // Counter saturation: 2049 words, odd so the pad is added on a saturated count
        b0 = q0.size(); b1 = q1.size();
        for (int i = 0; i < 2049; i++) send(32'(i + 1));
        send(END_W);
        wait_pulse(ok);
        check("t7_pulse", ok, 32'd1);
        check("t7_len_sat", iseq_len, 32'd2047);
        kicks_exp++;
        dispatch(2);
        check("t7_n0", q0.size() - b0, 32'd1025);
        check("t7_n1", q1.size() - b1, 32'd1025);
        check("t7_last0", q0[b0+1024], 32'd2049);
        check("t7_pad", q1[b1+1024], NOP);
`ifdef ISEQ_LOADER_STATS_EN
        check("t7_kicks", iseq_kick_cnt, kicks_exp);
`endif

        check("fifo_rules", viol, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
